// File: rtl/slice_scheduler.sv
// slice_scheduler: measures the rotor period between index pulses and splits it into NUM_SLICES strobes.
// Build option: define SLICE_DITHER_EN to spread the period remainder so the slices sum to exactly the period.
module slice_scheduler #(
  parameter int unsigned NUM_SLICES = 256,
  parameter int unsigned PERIOD_W   = 27,
  parameter int unsigned MIN_PERIOD = 1024,
  parameter int unsigned MAX_PERIOD = 134217727
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          index_in,
  output logic                          slice_strobe_out,
  output logic [$clog2(NUM_SLICES)-1:0] slice_idx_out,
  output logic [PERIOD_W-1:0]           period_out,
  output logic                          locked_out
);

  localparam int unsigned          IDX_W    = $clog2(NUM_SLICES);
  localparam logic [PERIOD_W-1:0]  MIN_P    = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0]  MAX_P    = PERIOD_W'(MAX_PERIOD);
  localparam logic [PERIOD_W-1:0]  ONE_P    = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0]  ZERO_P   = {PERIOD_W{1'b0}};
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_SLICES - 1);
  localparam logic [IDX_W-1:0]     ZERO_IDX = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]     ONE_IDX  = IDX_W'(1);
`ifdef SLICE_DITHER_EN
  localparam logic [IDX_W:0]       NUM_W    = (IDX_W + 1)'(NUM_SLICES);
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t              state_q,  state_d;
  logic [PERIOD_W-1:0] cnt_q,    cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] base_q,   base_d;
  logic [PERIOD_W-1:0] timer_q,  timer_d;
  logic [IDX_W-1:0]    idx_q,    idx_d;
  logic                strobe_q, strobe_d;
  logic                locked_q, locked_d;
`ifdef SLICE_DITHER_EN
  logic [IDX_W-1:0]    rem_q,    rem_d;
  logic [IDX_W:0]      acc_q,    acc_d;
  logic [IDX_W:0]      adv_sum_s;
`endif

  logic                accept_s;
  logic                adv_extra_s;
  logic [PERIOD_W-1:0] new_base_s;

  // Next-state logic: period measurement, lock FSM and slice sequencing.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    base_d   = base_q;
    timer_d  = timer_q;
    idx_d    = idx_q;
    strobe_d = 1'b0;
    locked_d = locked_q;
`ifdef SLICE_DITHER_EN
    rem_d       = rem_q;
    acc_d       = acc_q;
    adv_sum_s   = acc_q + {1'b0, rem_q};
    adv_extra_s = (adv_sum_s >= NUM_W);
`else
    adv_extra_s = 1'b0;
`endif
    accept_s   = index_in && (cnt_q >= MIN_P);
    new_base_s = cnt_q >> IDX_W;

    case (state_q)
      ST_IDLE: begin
        if (index_in) begin
          state_d = ST_MEASURE;
          cnt_d   = ONE_P;
        end else begin
          cnt_d   = ZERO_P;
        end
      end
      ST_MEASURE, ST_RUN: begin
        if (accept_s) begin
          // Slice 0 never carries the extra cycle: the remainder alone is below NUM_SLICES.
          state_d  = ST_RUN;
          cnt_d    = ONE_P;
          period_d = cnt_q;
          base_d   = new_base_s;
          timer_d  = new_base_s - ONE_P;
          idx_d    = ZERO_IDX;
          strobe_d = 1'b1;
          locked_d = 1'b1;
`ifdef SLICE_DITHER_EN
          rem_d    = cnt_q[IDX_W-1:0];
          acc_d    = {1'b0, cnt_q[IDX_W-1:0]};
`endif
        end else if (cnt_q == MAX_P) begin
          state_d  = ST_IDLE;
          cnt_d    = ZERO_P;
          period_d = ZERO_P;
          base_d   = ZERO_P;
          timer_d  = ZERO_P;
          idx_d    = ZERO_IDX;
          locked_d = 1'b0;
`ifdef SLICE_DITHER_EN
          rem_d    = ZERO_IDX;
          acc_d    = {1'b0, ZERO_IDX};
`endif
        end else begin
          cnt_d = cnt_q + ONE_P;
          if (state_q == ST_RUN) begin
            if (timer_q != ZERO_P) begin
              timer_d = timer_q - ONE_P;
            end else if (idx_q != LAST_IDX) begin
              idx_d    = idx_q + ONE_IDX;
              strobe_d = 1'b1;
              timer_d  = base_q - ONE_P + PERIOD_W'(adv_extra_s);
`ifdef SLICE_DITHER_EN
              acc_d    = adv_extra_s ? (adv_sum_s - NUM_W) : adv_sum_s;
`endif
            end else begin
              // Last slice finished: hold the index until the next accepted index or timeout.
              timer_d = timer_q;
            end
          end else begin
            timer_d = timer_q;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        cnt_d    = ZERO_P;
        period_d = ZERO_P;
        base_d   = ZERO_P;
        timer_d  = ZERO_P;
        idx_d    = ZERO_IDX;
        locked_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q  <= ST_IDLE;
      cnt_q    <= ZERO_P;
      period_q <= ZERO_P;
      base_q   <= ZERO_P;
      timer_q  <= ZERO_P;
      idx_q    <= ZERO_IDX;
      strobe_q <= 1'b0;
      locked_q <= 1'b0;
`ifdef SLICE_DITHER_EN
      rem_q    <= ZERO_IDX;
      acc_q    <= {1'b0, ZERO_IDX};
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      base_q   <= base_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      strobe_q <= strobe_d;
      locked_q <= locked_d;
`ifdef SLICE_DITHER_EN
      rem_q    <= rem_d;
      acc_q    <= acc_d;
`endif
    end
  end

  assign slice_strobe_out = strobe_q;
  assign slice_idx_out    = idx_q;
  assign period_out       = period_q;
  assign locked_out       = locked_q;

endmodule

// File: doc/slice_scheduler.md
# slice_scheduler

Converts the once-per-revolution index pulse from the rotor's hall sensor into evenly spaced slice strobes. It measures the rotation period in clock cycles, divides that period into `NUM_SLICES` angular slices, and emits one strobe plus a slice index per slice. It sits between the synchronized, debounced hall-sensor input and the frame/column fetch logic, and is the timing master for every per-slice update in the display.

## Interface
- `NUM_SLICES`, 256: slices per revolution; power of two, at least 2.
- `PERIOD_W`, 27: width of the period counter and `period_out`.
- `MIN_PERIOD`, 1024: shortest accepted period in cycles; must be at least `NUM_SLICES`.
- `MAX_PERIOD`, 2^27-1: timeout; no index for this many cycles drops lock.
- `clk_in`, input, 1: system clock.
- `rst_in`, input, 1: reset. One clock; reset is synchronous and active-low.
- `index_in`, input, 1: single-cycle index pulse, already synchronized to `clk_in`.
- `slice_strobe_out`, output, 1: single-cycle pulse at the start of each slice.
- `slice_idx_out`, output, log2(`NUM_SLICES`): index of the current slice.
- `period_out`, output, `PERIOD_W`: last accepted period in cycles.
- `locked_out`, output, 1: high while in RUN.

## Operation
- Reset values (`rst_in`=0): state IDLE, all outputs 0, period counter 0, slice timer 0.
- Period counter:
  - An accepted index loads the counter with 1.
  - Otherwise the counter increments every cycle and saturates at `MAX_PERIOD`.
  - The measured period P is the counter value at the next index, which equals the number of cycles between the two index pulses.
- Acceptance rule: in MEASURE and RUN, an index is accepted only if P >= `MIN_PERIOD`. A shorter index is a glitch: it is ignored and the counter keeps running. In IDLE, every index is accepted.
- States:
  - IDLE → MEASURE on any index. The counter starts.
  - MEASURE → RUN on an accepted index. `period_out` takes P.
  - MEASURE → IDLE when the counter reaches `MAX_PERIOD`.
  - RUN → RUN on an accepted index. `period_out` takes P and slicing restarts.
  - RUN → IDLE when the counter reaches `MAX_PERIOD`. On this transition `locked_out`, `slice_idx_out` and `period_out` clear to 0.
- Slicing in RUN:
  - Base slice length L = P >> log2(`NUM_SLICES`). L >= 1 is guaranteed by the minimum-period rule.
  - An accepted index starts slice 0. Each slice lasts its length in cycles; at the end, `slice_idx_out` increments and a strobe fires.
  - After slice `NUM_SLICES`-1 the block emits no further strobes. It holds that index until the next index or timeout; `slice_idx_out` never wraps on its own.
- Early index (before the last slice): slicing restarts at slice 0 immediately, using the new L.
- Simultaneous events: an index in the same cycle as a slice-timer terminal count wins. The slice restart replaces the increment, so exactly one strobe fires, for slice 0.
- Strobes never occur outside RUN.

## Timing
- Index accepted at cycle t:
  - MEASURE→RUN or RUN→RUN: `period_out` updates, `locked_out` is 1, `slice_idx_out`=0 and `slice_strobe_out`=1, all at t+1.
  - IDLE→MEASURE: no strobe.
- Without dither, slice k strobes at t+1+k·L.
- Timeout: if the counter reaches `MAX_PERIOD` at cycle t, the IDLE outputs are visible at t+1.
- Reset asserted mid-revolution takes effect on the next edge. No strobe fires in the cycle after reset.
- All outputs are registered. There is no combinational path from `index_in` to any output.

## Configuration
- `SLICE_DITHER_EN` defined: remainder R = P mod `NUM_SLICES` is spread across the slices so the slices sum to exactly P.
  - An accumulator clears on each accepted index.
  - At the start of every slice, R is added to the accumulator. If the result is >= `NUM_SLICES`, `NUM_SLICES` is subtracted and that slice lasts L+1.
- `SLICE_DITHER_EN` not defined: every slice lasts L. The final slice ends R cycles before the next index, and the index is then held.

## Test plan
Parameters for all scenarios: `NUM_SLICES`=4, `MIN_PERIOD`=16, `MAX_PERIOD`=1000.
- Lock-up: index pulses at cycles 10, 110, 210 → `locked_out` rises at 111, `period_out`=100. Strobes at 111, 136, 161, 186 with idx 0..3; next strobe at 211, idx 0.
- Dither (`SLICE_DITHER_EN` defined): index period 102 → slice lengths 25, 26, 25, 26 and 4 strobes per revolution. Without the macro: lengths 25, 25, 25, 25, then idx 3 is held for 2 extra cycles.
- Glitch: extra index 5 cycles after a valid index → ignored. Period and strobes unchanged.
- Early index and collision:
  - Change the period from 100 to 60 → strobes restart at idx 0 with L=15.
  - Index on the same cycle as a slice terminal → exactly one strobe, with idx 0.
- Timeout: stop index pulses → 1000 cycles after the last index, `locked_out`=0, `period_out`=0, no strobes. A new index → MEASURE, then relock on the second index.
- Reset mid-run: pull `rst_in` low during slice 2 → all outputs 0 on the next cycle. After release, a single index gives no strobe.
